// File: rtl/wb_pkg.sv
// Shared widths, flag bit positions and the result-entry layout for the
// register-bank write-back path.
package wb_pkg;
  localparam int DW = 8;
  localparam int AW = 3;

  localparam int FLAG_C = 3;
  localparam int FLAG_O = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_Z = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          flagwr;
    logic [3:0]    flags;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous result FIFO; push is ignored when full, pop is ignored when empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type T = wb_entry_t
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/writeback_unit.sv
// Write-side driver for the register bank: arbitrates ALU/load results into a
// FIFO, drains one entry per cycle to the bank port and tracks pending writes.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = wb_pkg::DW,
  parameter int AW    = wb_pkg::AW
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 AluValid,
  input  logic [AW-1:0]        AluAddr,
  input  logic [DW-1:0]        AluData,
  input  logic                 AluFlagWR,
  input  logic [3:0]           AluFlags,
  output logic                 AluReady,
  input  logic                 MemValid,
  input  logic [AW-1:0]        MemAddr,
  input  logic [DW-1:0]        MemData,
  output logic                 MemReady,
  input  logic                 IssueValid,
  input  logic [AW-1:0]        IssueAddr,
  output logic [(2**AW)-1:0]   Busy,
  output logic                 WR,
  output logic [AW-1:0]        AddrWR,
  output logic [DW-1:0]        Datain,
  output logic                 FlagWR,
  output logic                 Cin,
  output logic                 Oin,
  output logic                 Sin,
  output logic                 Zin,
  output logic                 Err
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          flagwr;
    logic [3:0]    flags;
  } entry_t;

  entry_t              push_entry;
  entry_t              head;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                alu_acc;
  logic                mem_acc;
  logic                push;
  logic                pop;
  logic                clear_hit;
  logic                err_set;
  logic [(2**AW)-1:0]  busy_next;

  // Handshake: a source transfers on the cycle its Valid and Ready are both
  // high; Ready never depends on the source's own Valid, and the ALU wins ties.
  assign AluReady = RST_N & ~fifo_full;
  assign MemReady = RST_N & ~fifo_full & ~AluValid;
  assign alu_acc  = AluValid & AluReady;
  assign mem_acc  = MemValid & MemReady;
  assign push     = alu_acc | mem_acc;
  assign pop      = ~fifo_empty;

  always_comb begin
    push_entry = '0;
    if (alu_acc) begin
      push_entry.addr   = AluAddr;
      push_entry.data   = AluData;
      push_entry.flagwr = AluFlagWR;
      push_entry.flags  = AluFlags;
    end else begin
      push_entry.addr = MemAddr;
      push_entry.data = MemData;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Set beats clear when an issue and a drain hit the same register.
  always_comb begin
    clear_hit = pop && (head.addr == IssueAddr);
    busy_next = Busy;
    if (pop)        busy_next[head.addr] = 1'b0;
    if (IssueValid) busy_next[IssueAddr] = 1'b1;
    err_set = 1'b0;
    if (IssueValid && Busy[IssueAddr] && !clear_hit) err_set = 1'b1;
    if (push && !Busy[push_entry.addr])              err_set = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      WR     <= 1'b0;
      FlagWR <= 1'b0;
      AddrWR <= '0;
      Datain <= '0;
      Cin    <= 1'b0;
      Oin    <= 1'b0;
      Sin    <= 1'b0;
      Zin    <= 1'b0;
      Busy   <= '0;
      Err    <= 1'b0;
    end else begin
      WR     <= pop;
      FlagWR <= pop & head.flagwr;
      if (pop) begin
        AddrWR <= head.addr;
        Datain <= head.data;
        Cin    <= head.flags[FLAG_C];
        Oin    <= head.flags[FLAG_O];
        Sin    <= head.flags[FLAG_S];
        Zin    <= head.flags[FLAG_Z];
      end
      Busy <= busy_next;
      if (err_set) Err <= 1'b1;
    end
  end

  a_count_bound: assert property (@(posedge CLK) disable iff (!RST_N)
    fifo_count <= CW'(DEPTH));
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the result path and scoreboard.
module tb_writeback_unit;
  localparam int DEPTH = 2;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int NREG  = 2**AW;
  localparam int EW    = AW + DW + 5;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            AluValid, AluFlagWR, MemValid, IssueValid;
  logic [AW-1:0]   AluAddr, MemAddr, IssueAddr;
  logic [DW-1:0]   AluData, MemData;
  logic [3:0]      AluFlags;
  logic            AluReady, MemReady;
  logic [NREG-1:0] Busy;
  logic            WR, FlagWR, Cin, Oin, Sin, Zin, Err;
  logic [AW-1:0]   AddrWR;
  logic [DW-1:0]   Datain;

  int checks = 0;
  int errors = 0;

  // Reference model state: queued entries {addr,data,flagwr,flags}
  logic [EW-1:0]   exp_q[$];
  logic [NREG-1:0] m_busy;
  logic            m_err, m_wr, m_fwr;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic [3:0]      m_flags;

  writeback_unit #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData),
    .AluFlagWR(AluFlagWR), .AluFlags(AluFlags), .AluReady(AluReady),
    .MemValid(MemValid), .MemAddr(MemAddr), .MemData(MemData), .MemReady(MemReady),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr), .Busy(Busy),
    .WR(WR), .AddrWR(AddrWR), .Datain(Datain), .FlagWR(FlagWR),
    .Cin(Cin), .Oin(Oin), .Sin(Sin), .Zin(Zin), .Err(Err)
  );

  always #5 CLK = ~CLK;

  function automatic void model_edge();
    logic [NREG-1:0] pre;
    logic [EW-1:0]   e;
    logic            popped;
    int              n;
    if (!RST_N) begin
      exp_q.delete();
      m_busy = '0; m_err = 1'b0; m_wr = 1'b0; m_fwr = 1'b0;
      m_addr = '0; m_data = '0; m_flags = '0;
      return;
    end
    n      = exp_q.size();
    pre    = m_busy;
    popped = (n > 0);
    if (popped) begin
      e       = exp_q.pop_front();
      m_wr    = 1'b1;
      m_fwr   = e[4];
      m_addr  = e[15:13];
      m_data  = e[12:5];
      m_flags = e[3:0];
      m_busy[m_addr] = 1'b0;
    end else begin
      m_wr  = 1'b0;
      m_fwr = 1'b0;
    end
    if (IssueValid) begin
      if (pre[IssueAddr] && !(popped && m_addr == IssueAddr)) m_err = 1'b1;
      m_busy[IssueAddr] = 1'b1;
    end
    if (n < DEPTH) begin
      if (AluValid) begin
        if (!pre[AluAddr]) m_err = 1'b1;
        exp_q.push_back({AluAddr, AluData, AluFlagWR, AluFlags});
      end else if (MemValid) begin
        if (!pre[MemAddr]) m_err = 1'b1;
        exp_q.push_back({MemAddr, MemData, 1'b0, 4'b0000});
      end
    end
  endfunction

  task automatic clk_edge();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    AluValid = 1'b0; AluAddr = '0; AluData = '0; AluFlagWR = 1'b0; AluFlags = '0;
    MemValid = 1'b0; MemAddr = '0; MemData = '0;
    IssueValid = 1'b0; IssueAddr = '0;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    IssueValid = 1'b1; IssueAddr = a;
    clk_edge();
    IssueValid = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    idle_inputs();
    clk_edge();
    clk_edge();
    checks++;
    if ({WR, FlagWR, AddrWR, Datain, Cin, Oin, Sin, Zin, Busy, Err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got WR=%b FlagWR=%b AddrWR=%0h Datain=%0h flags=%b Busy=%0h Err=%b expected all 0",
               WR, FlagWR, AddrWR, Datain, {Cin, Oin, Sin, Zin}, Busy, Err);
    end
    @(negedge CLK);
    checks++;
    if ({AluReady, MemReady} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 00", {AluReady, MemReady});
    end
    clk_edge();
    RST_N = 1'b1;
    #1;
    checks++;
    if ({AluReady, MemReady} !== 2'b11) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 11", {AluReady, MemReady});
    end
  endtask

  task automatic test_alu_flag_write();
    issue(3'd3);
    checks++;
    if (Busy !== 8'h08) begin
      errors++;
      $display("FAIL busy_set_r3: got %0h expected 08", Busy);
    end
    AluValid = 1'b1; AluAddr = 3'd3; AluData = 8'h5A; AluFlagWR = 1'b1; AluFlags = 4'b1010;
    @(negedge CLK);
    checks++;
    if (AluReady !== 1'b1) begin
      errors++;
      $display("FAIL alu_ready_empty: got %b expected 1", AluReady);
    end
    clk_edge();
    AluValid = 1'b0;
    checks++;
    if (WR !== 1'b0) begin
      errors++;
      $display("FAIL wr_not_early: got %b expected 0", WR);
    end
    clk_edge();
    checks++;
    if ({WR, AddrWR, Datain, FlagWR, Cin, Oin, Sin, Zin, Busy, Err} !==
        {1'b1, 3'd3, 8'h5A, 1'b1, 4'b1010, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL alu_write: got WR=%b AddrWR=%0d Datain=%0h FlagWR=%b flags=%b Busy=%0h Err=%b expected 1 3 5a 1 1010 00 0",
               WR, AddrWR, Datain, FlagWR, {Cin, Oin, Sin, Zin}, Busy, Err);
    end
    clk_edge();
    checks++;
    if ({WR, FlagWR, Datain} !== {1'b0, 1'b0, 8'h5A}) begin
      errors++;
      $display("FAIL single_strobe: got WR=%b FlagWR=%b Datain=%0h expected 0 0 5a", WR, FlagWR, Datain);
    end
  endtask

  task automatic test_priority();
    issue(3'd1);
    issue(3'd2);
    AluValid = 1'b1; AluAddr = 3'd1; AluData = 8'h11; AluFlagWR = 1'b0; AluFlags = 4'b0000;
    MemValid = 1'b1; MemAddr = 3'd2; MemData = 8'h22;
    @(negedge CLK);
    checks++;
    if ({AluReady, MemReady} !== 2'b10) begin
      errors++;
      $display("FAIL both_valid_ready: got %b expected 10", {AluReady, MemReady});
    end
    clk_edge();
    AluValid = 1'b0;
    @(negedge CLK);
    checks++;
    if (MemReady !== 1'b1) begin
      errors++;
      $display("FAIL mem_ready_next: got %b expected 1", MemReady);
    end
    clk_edge();
    MemValid = 1'b0;
    checks++;
    if ({WR, AddrWR, Datain, FlagWR} !== {1'b1, 3'd1, 8'h11, 1'b0}) begin
      errors++;
      $display("FAIL alu_first: got WR=%b AddrWR=%0d Datain=%0h FlagWR=%b expected 1 1 11 0", WR, AddrWR, Datain, FlagWR);
    end
    clk_edge();
    checks++;
    if ({WR, AddrWR, Datain, FlagWR} !== {1'b1, 3'd2, 8'h22, 1'b0}) begin
      errors++;
      $display("FAIL mem_second: got WR=%b AddrWR=%0d Datain=%0h FlagWR=%b expected 1 2 22 0", WR, AddrWR, Datain, FlagWR);
    end
    clk_edge();
    checks++;
    if ({WR, Busy, Err} !== {1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL priority_drained: got WR=%b Busy=%0h Err=%b expected 0 00 0", WR, Busy, Err);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW+DW-1:0] wr_q[$];
    logic [AW+DW-1:0] w;
    int writes = 0;
    for (int i = 0; i < 6; i++) issue(AW'(i));
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        AluValid = 1'b1; AluAddr = AW'(i); AluData = DW'($urandom_range(0, 255));
        AluFlagWR = 1'b0; AluFlags = 4'b0000;
        wr_q.push_back({AluAddr, AluData});
        @(negedge CLK);
        checks++;
        if (AluReady !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready[%0d]: got %b expected 1", i, AluReady);
        end
      end else begin
        AluValid = 1'b0;
      end
      clk_edge();
      checks++;
      if (WR !== (i >= 1 && i <= 6)) begin
        errors++;
        $display("FAIL b2b_wr[%0d]: got %b expected %b", i, WR, (i >= 1 && i <= 6));
      end
      if (WR === 1'b1) begin
        writes++;
        w = (wr_q.size() > 0) ? wr_q.pop_front() : '1;
        checks++;
        if ({AddrWR, Datain} !== w) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, {AddrWR, Datain}, w);
        end
      end
    end
    checks++;
    if (writes != 6 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes, %0d left expected 6 writes, 0 left", writes, wr_q.size());
    end
  endtask

  task automatic test_scoreboard();
    issue(3'd5);
    AluValid = 1'b1; AluAddr = 3'd5; AluData = 8'h55; AluFlagWR = 1'b0; AluFlags = 4'b0000;
    clk_edge();
    AluValid = 1'b0;
    IssueValid = 1'b1; IssueAddr = 3'd5;
    clk_edge();
    checks++;
    if ({WR, AddrWR, Busy[5], Err} !== {1'b1, 3'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL set_wins: got WR=%b AddrWR=%0d Busy5=%b Err=%b expected 1 5 1 0", WR, AddrWR, Busy[5], Err);
    end
    clk_edge();
    IssueValid = 1'b0;
    checks++;
    if ({Busy[5], Err} !== 2'b11) begin
      errors++;
      $display("FAIL double_issue_err: got Busy5=%b Err=%b expected 1 1", Busy[5], Err);
    end
  endtask

  task automatic test_random();
    logic ea, em;
    logic [25:0] act, exp_v;
    for (int i = 0; i < 400; i++) begin
      RST_N      = ($urandom_range(0, 49) != 0);
      AluValid   = 1'($urandom_range(0, 1));
      AluAddr    = AW'($urandom_range(0, NREG-1));
      AluData    = DW'($urandom_range(0, 255));
      AluFlagWR  = 1'($urandom_range(0, 1));
      AluFlags   = 4'($urandom_range(0, 15));
      MemValid   = 1'($urandom_range(0, 1));
      MemAddr    = AW'($urandom_range(0, NREG-1));
      MemData    = DW'($urandom_range(0, 255));
      IssueValid = ($urandom_range(0, 2) == 0);
      IssueAddr  = AW'($urandom_range(0, NREG-1));
      @(negedge CLK);
      ea = RST_N && (exp_q.size() < DEPTH);
      em = ea && !AluValid;
      checks++;
      if ({AluReady, MemReady} !== {ea, em}) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", i, {AluReady, MemReady}, {ea, em});
      end
      clk_edge();
      act   = {WR, FlagWR, AddrWR, Datain, Cin, Oin, Sin, Zin, Busy, Err};
      exp_v = {m_wr, m_fwr, m_addr, m_data, m_flags, m_busy, m_err};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL rand_out[%0d]: got %0h expected %0h", i, act, exp_v);
      end
    end
    idle_inputs();
    RST_N = 1'b1;
  endtask

  task automatic test_reset_midop();
    RST_N = 1'b0;
    clk_edge();
    RST_N = 1'b1;
    for (int i = 0; i < NREG; i++) issue(AW'(i));
    checks++;
    if (Busy !== 8'hFF) begin
      errors++;
      $display("FAIL busy_all: got %0h expected ff", Busy);
    end
    AluValid = 1'b1; AluAddr = 3'd1; AluData = 8'hA1; AluFlagWR = 1'b1; AluFlags = 4'b1111;
    clk_edge();
    AluValid = 1'b0;
    MemValid = 1'b1; MemAddr = 3'd2; MemData = 8'hB2;
    clk_edge();
    MemValid = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK);
    checks++;
    if ({AluReady, MemReady} !== 2'b00) begin
      errors++;
      $display("FAIL midop_reset_ready: got %b expected 00", {AluReady, MemReady});
    end
    clk_edge();
    checks++;
    if ({WR, FlagWR, AddrWR, Datain, Cin, Oin, Sin, Zin, Busy, Err} !== '0) begin
      errors++;
      $display("FAIL midop_reset_outputs: got WR=%b FlagWR=%b AddrWR=%0h Datain=%0h flags=%b Busy=%0h Err=%b expected all 0",
               WR, FlagWR, AddrWR, Datain, {Cin, Oin, Sin, Zin}, Busy, Err);
    end
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clk_edge();
      checks++;
      if ({WR, FlagWR} !== 2'b00) begin
        errors++;
        $display("FAIL dropped_entry_wr[%0d]: got %b expected 00", i, {WR, FlagWR});
      end
    end
  endtask

  initial begin
    idle_inputs();
    RST_N = 1'b0;
    test_reset();
    test_alu_flag_write();
    test_priority();
    test_back_to_back();
    test_scoreboard();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
